// File: rtl/alu_pkg.sv
// Shared opcodes, NZP encodings and arbiter state type for the ALU arbiter slice.
package alu_pkg;
   localparam logic [3:0] OP_CMP = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0101;
   localparam logic [3:0] OP_DIV = 4'b0110;

   localparam logic [2:0] NZP_N = 3'b100;
   localparam logic [2:0] NZP_Z = 3'b010;
   localparam logic [2:0] NZP_P = 3'b001;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first requester after 'last', wrapping.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] grant,
   output logic          any
);
   logic [IW:0]   sum_w [N];
   logic [IW-1:0] idx_w [N];

   // idx_w[k] is the k-th candidate in search order: (last + 1 + k) mod N.
   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign sum_w[gi] = {1'b0, last} + (IW+1)'(gi + 1);
      assign idx_w[gi] = (sum_w[gi] >= (IW+1)'(N)) ? IW'(sum_w[gi] - (IW+1)'(N))
                                                   : sum_w[gi][IW-1:0];
   end

   always_comb begin
      grant = '0;
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any && req[idx_w[k]]) begin
            any   = 1'b1;
            grant = idx_w[k];
         end
      end
   end
endmodule

// File: rtl/simple_alu.sv
// Combinational 8-bit ALU; CMP sets signed NZP, every other opcode leaves NZP clear.
module simple_alu
   import alu_pkg::*;
(
   input  logic [3:0] op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] result,
   output logic [2:0] nzp
);
   always_comb begin
      result = '0;
      nzp    = '0;
      case (op)
         OP_CMP: begin
            if ($signed(a) < $signed(b))
               nzp = NZP_N;
            else if (a == b)
               nzp = NZP_Z;
            else
               nzp = NZP_P;
         end
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_MUL:  result = a * b;
         // Divide by zero yields 0 rather than trapping.
         OP_DIV:  result = (b == 8'd0) ? 8'd0 : a / b;
         default: result = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one simple_alu between NUM_REQ requesters.
// One op in flight at a time: IDLE accepts, EXEC computes, DONE pulses the response.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_BITS  = 8,
   parameter int DIV_CYCLES = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*4-1:0]           req_op,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_a,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_b,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_BITS-1:0]           rsp_result,
   output logic [2:0]                     rsp_nzp,
   output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
   output logic                           busy
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(DIV_CYCLES + 1);

   arb_state_t           state_q, state_d;
   logic [IW-1:0]        last_q, last_d;
   logic [IW-1:0]        id_q, id_d;
   logic [3:0]           op_q, op_d;
   logic [DATA_BITS-1:0] a_q, a_d;
   logic [DATA_BITS-1:0] b_q, b_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] rsp_result_q, rsp_result_d;
   logic [2:0]           rsp_nzp_q, rsp_nzp_d;
   logic [IW-1:0]        rsp_id_q, rsp_id_d;

   logic [3:0]           op_arr [NUM_REQ];
   logic [DATA_BITS-1:0] a_arr  [NUM_REQ];
   logic [DATA_BITS-1:0] b_arr  [NUM_REQ];
   logic [IW-1:0]        grant;
   logic                 any;
   logic [7:0]           alu_result;
   logic [2:0]           alu_nzp;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
      assign op_arr[gi]    = req_op[4*gi +: 4];
      assign a_arr[gi]     = req_a[DATA_BITS*gi +: DATA_BITS];
      assign b_arr[gi]     = req_b[DATA_BITS*gi +: DATA_BITS];
      assign req_ready[gi] = (state_q == IDLE) && any && (grant == IW'(gi));
      assign rsp_valid[gi] = (state_q == DONE) && (id_q == IW'(gi));
   end

   rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
      .req   (req_valid),
      .last  (last_q),
      .grant (grant),
      .any   (any)
   );

   // The ALU only ever sees latched operands, so requester inputs may change during EXEC.
   simple_alu u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .nzp    (alu_nzp)
   );

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      id_d         = id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      cnt_d        = cnt_q;
      rsp_result_d = rsp_result_q;
      rsp_nzp_d    = rsp_nzp_q;
      rsp_id_d     = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (any) begin
               op_d    = op_arr[grant];
               a_d     = a_arr[grant];
               b_d     = b_arr[grant];
               id_d    = grant;
               last_d  = grant;
               cnt_d   = (op_arr[grant] == OP_DIV) ? CW'(DIV_CYCLES - 1) : '0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               rsp_result_d = alu_result;
               rsp_nzp_d    = alu_nzp;
               rsp_id_d     = id_q;
               state_d      = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_q       <= IW'(NUM_REQ - 1);
         id_q         <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         cnt_q        <= '0;
         rsp_result_q <= '0;
         rsp_nzp_q    <= '0;
         rsp_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         id_q         <= id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cnt_q        <= cnt_d;
         rsp_result_q <= rsp_result_d;
         rsp_nzp_q    <= rsp_nzp_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign rsp_result = rsp_result_q;
   assign rsp_nzp    = rsp_nzp_q;
   assign rsp_id     = rsp_id_q;
   assign busy       = (state_q != IDLE);
endmodule
